// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl
//   Multi-cycle restoring divider that owns the HI/LO result registers of a
//   MIPS-style pipeline. It supports DIV (signed) and DIVU (unsigned).
//
//   The divider works on magnitudes. The quotient and remainder signs are
//   fixed up after the 32 shift-subtract steps. When the divisor is zero, the
//   iterations are skipped: lo is set to all ones and hi to the raw dividend.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : division request (accepted only in IDLE or DONE)
//   sign    : 1 = DIV (signed), 0 = DIVU (unsigned)
//   a, b    : dividend / divisor, sampled with start
//   rd_req  : pipeline wants MFHI/MFLO this cycle
//   busy    : division in progress (SETUP, ITER, FIXUP)
//   done    : one-cycle pulse, hi/lo hold the new result
//   stall   : rd_req AND busy (combinational)
//   hi, lo  : remainder / quotient registers
// -----------------------------------------------------------------------------
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Two's-complement negation, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CW-1:0]      cnt_r;
    logic               sign_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   quot_r;   // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0]   divs_r;   // divisor magnitude
    logic [WIDTH:0]     rem_r;    // one spare bit so the shift never overflows
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     diff_s;
    logic               q_bit_s;

    // Operand signs and magnitudes; negation only applies to signed division.
    always_comb begin
        a_neg_s = sign_r & a_r[WIDTH-1];
        b_neg_s = sign_r & b_r[WIDTH-1];
        if (a_neg_s) begin
            abs_a_s = negate(a_r);
        end else begin
            abs_a_s = a_r;
        end
        if (b_neg_s) begin
            abs_b_s = negate(b_r);
        end else begin
            abs_b_s = b_r;
        end
    end

    // One restoring step. A clear borrow bit means the divisor fits,
    // so this quotient bit is 1.
    always_comb begin
        shift_s = {rem_r[WIDTH-1:0], quot_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, divs_r};
        q_bit_s = ~diff_s[WIDTH];
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (b_r == {WIDTH{1'b0}}) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ITER;
                end
            end
            ITER: begin
                if (cnt_r == LAST) begin
                    state_next_s = FIXUP;
                end else begin
                    state_next_s = ITER;
                end
            end
            FIXUP: begin
                state_next_s = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == SETUP) || (state_next_s == ITER) ||
                       (state_next_s == FIXUP);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Datapath: operand capture, iteration, sign fix-up and result write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            sign_r <= 1'b0;
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            quot_r <= {WIDTH{1'b0}};
            divs_r <= {WIDTH{1'b0}};
            rem_r  <= {(WIDTH+1){1'b0}};
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // hi/lo are left alone so a restart from DONE keeps
                    // the result being presented.
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        sign_r <= sign;
                    end
                end
                SETUP: begin
                    quot_r <= abs_a_s;
                    divs_r <= abs_b_s;
                    rem_r  <= {(WIDTH+1){1'b0}};
                    cnt_r  <= {CW{1'b0}};
                    if (b_r == {WIDTH{1'b0}}) begin
                        // Divide by zero: raw dividend into hi, regardless of sign.
                        hi_r <= a_r;
                        lo_r <= {WIDTH{1'b1}};
                    end
                end
                ITER: begin
                    if (q_bit_s) begin
                        rem_r <= diff_s;
                    end else begin
                        rem_r <= shift_s;
                    end
                    quot_r <= {quot_r[WIDTH-2:0], q_bit_s};
                    cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                FIXUP: begin
                    // 0x80000000 / -1 wraps back to 0x80000000 here.
                    if (a_neg_s ^ b_neg_s) begin
                        lo_r <= negate(quot_r);
                    end else begin
                        lo_r <= quot_r;
                    end
                    // The remainder takes the sign of the dividend.
                    if (a_neg_s) begin
                        hi_r <= negate(rem_r[WIDTH-1:0]);
                    end else begin
                        hi_r <= rem_r[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = rd_req & busy_r;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl
//   Directed-vector bench for hilo_div_ctrl.
//
//   The driver issues a division and pushes the hand-computed hi/lo pair and
//   the expected done cycle onto a queue. An independent monitor pops that
//   entry when done rises. On every other cycle, the monitor checks that
//   hi/lo still hold the last result (or zero under reset). It also checks
//   that stall follows rd_req & busy.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] hold_hi     = 32'd0;
    logic [31:0] hold_lo     = 32'd0;

    hilo_div_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .rd_req (rd_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, stepped on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid low phase, after the driver has settled its inputs.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            chk("reset_hi", hi, 32'd0);
            chk("reset_lo", lo, 32'd0);
            chk("reset_busy", {31'd0, busy}, 32'd0);
            chk("reset_done", {31'd0, done}, 32'd0);
            chk("reset_stall", {31'd0, stall}, 32'd0);
            hold_hi = 32'd0;
            hold_lo = 32'd0;
        end else begin
            chk("stall_eq", {31'd0, stall}, {31'd0, rd_req & busy});
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no result pending (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("result_hi", hi, e.hi);
                    chk("result_lo", lo, e.lo);
                    chk("done_cycle", cyc, e.cyc);
                    hold_hi = e.hi;
                    hold_lo = e.lo;
                end
            end else begin
                chk("hold_hi", hi, hold_hi);
                chk("hold_lo", lo, hold_lo);
            end
        end
    end

    // Drives one operation from a falling edge and follows it to its done cycle.
    // If inj is non-zero, a second start (50/5) is pulsed in loop cycle inj.
    task automatic issue_and_track(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                                   input logic [31:0] eh, input logic [31:0] el,
                                   input int lat, input int inj);
        int   e0;
        exp_t e;
        sign  = s;
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = e0 + lat;
        sb_q.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy_during", {31'd0, busy}, 32'd1);
            chk("done_early", {31'd0, done}, 32'd0);
            if (rd_req) begin
                chk("stall_during", {31'd0, stall}, 32'd1);
            end
            if (k == inj) begin
                start = 1'b1;
                sign  = 1'b0;
                a     = 32'd50;
                b     = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_latency", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("stall_at_done", {31'd0, stall}, 32'd0);
    endtask

    task automatic run_op(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
        @(negedge clk);
        issue_and_track(s, aa, bb, eh, el, lat, 0);
    endtask

    // Safety net: the run must never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        sign   = 1'b0;
        a      = 32'd0;
        b      = 32'd0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // DIVU 100 / 7 = 14 r 2
        run_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        // DIV -7 / 2 = -3 r -1
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        // DIV 7 / -2 = -3 r 1
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);
        // DIV 0x80000000 / -1 wraps to 0x80000000 r 0
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
        // DIVU 0x80000000 / 0xFFFFFFFF = 0 r 0x80000000
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
        // DIVU by zero
        run_op(1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
        // DIV by zero keeps the raw negative dividend
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
        // DIV -100 / -7 = 14 r -2, then a back-to-back start taken in DONE
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 34);
        issue_and_track(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 34, 0);

        // Start 50/5 mid-ITER with rd_req held; only 1000/9 = 111 r 1 may appear
        @(negedge clk);
        rd_req = 1'b1;
        issue_and_track(1'b0, 32'd1000, 32'd9, 32'd1, 32'd111, 34, 15);
        rd_req = 1'b0;
        repeat (40) @(negedge clk);

        // Abort a DIVU at iteration 10, then restart right after release
        @(negedge clk);
        sign  = 1'b0;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n  = 1'b0;
        rd_req = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rd_req = 1'b0;
        issue_and_track(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 34, 0);

        repeat (40) @(negedge clk);
        chk("queue_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width; all values below assume WIDTH=32.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low; all state cleared immediately on assertion.
REQ-004 start  input  1  Division request, sampled on rising edge.
REQ-005 sign  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start.
REQ-006 a  input  WIDTH  Dividend; sampled with start.
REQ-007 b  input  WIDTH  Divisor; sampled with start.
REQ-008 rd_req  input  1  Pipeline is requesting MFHI/MFLO this cycle.
REQ-009 busy  output  1  Division in progress.
REQ-010 done  output  1  One-cycle pulse; hi/lo hold the new result.
REQ-011 stall  output  1  Combinational: rd_req AND busy.
REQ-012 hi  output  WIDTH  Remainder register (HI).
REQ-013 lo  output  WIDTH  Quotient register (LO).

Function
REQ-014 The block SHALL implement FSM states IDLE, SETUP, ITER, FIXUP and DONE, plus a 5-bit iteration counter.
REQ-015 In IDLE or DONE, start=1 SHALL latch a, b and sign, and move the FSM to SETUP.
REQ-016 Otherwise, DONE SHALL return to IDLE after one cycle.
REQ-017 start SHALL be ignored in SETUP, ITER and FIXUP, with no queuing and no effect on the operation in progress.
REQ-018 SETUP SHALL form the unsigned magnitudes |a| and |b| (two's-complement negation only when sign=1 and the MSB is set), clear the partial remainder, and clear the counter.
REQ-019 SETUP SHALL go to ITER when b != 0, and directly to DONE when b == 0.
REQ-020 Each ITER cycle SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first, with a WIDTH+1-bit partial remainder to prevent overflow.
REQ-021 ITER SHALL last exactly 32 cycles; on the cycle with counter == 31 the FSM SHALL go to FIXUP.
REQ-022 When sign=1, FIXUP SHALL negate the quotient if the signs of a and b differ.
REQ-023 When sign=1, FIXUP SHALL negate the remainder if a is negative (remainder takes the sign of the dividend).
REQ-024 Results SHALL be truncated to WIDTH bits and written to hi/lo on the FIXUP→DONE edge.
REQ-025 Latency: with start sampled at edge E0, done SHALL be high for exactly the cycle following edge E0+34 (35 cycles from E0).
REQ-026 Divide-by-zero SHALL produce lo=0xFFFFFFFF and hi=a (raw, regardless of sign), with done high in the cycle following E0+1.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0, through normal wrap-around with no special case.
REQ-028 busy SHALL be 1 exactly in SETUP, ITER and FIXUP, and 0 in IDLE and DONE.
REQ-029 hi and lo SHALL change only on the edge entering DONE (or on reset); otherwise they hold their last result.
REQ-030 A start accepted in DONE SHALL begin a new operation without disturbing the hi/lo values presented with the current done pulse.

Reset
REQ-031 While rst_n=0, the block SHALL hold: FSM=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, and all internal operand/partial registers=0.
REQ-032 Reset asserted mid-operation SHALL abort the operation: no done pulse, hi/lo=0, and a start on the first edge after release SHALL be accepted.
REQ-033 stall SHALL be 0 during reset, since busy=0.

Verification
REQ-034 DIVU a=100, b=7 SHALL give done at E0+35 with lo=14 and hi=2, busy high for cycles E0+1..E0+34, and no earlier change to hi/lo.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 SHALL give lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); DIV a=7, b=0xFFFFFFFE SHALL give lo=0xFFFFFFFD and hi=1.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0; DIVU with the same operands SHALL give lo=0 and hi=0x80000000.
REQ-037 DIVU a=0x1234, b=0 SHALL give done at E0+2, lo=0xFFFFFFFF and hi=0x1234, with busy high for one cycle only.
REQ-038 Reset pulsed at iteration 10 of a DIVU, followed by start (a=9, b=3) on the first edge after release, SHALL give no done from the aborted operation, hi=lo=0 until the new done, then lo=3 and hi=0.
REQ-039 start=1 with a=50, b=5 issued mid-ITER, with rd_req=1 held throughout, SHALL be ignored: the original result is unchanged, stall=1 exactly while busy=1, and stall=0 on the done cycle.
